bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter placed directly downstream of the digit-sum adder.
- Takes the 10-bit binary sum (0..1023) and converts it to four BCD digits for the seven-segment display driver.
- Uses the iterative shift-add-3 (double dabble) algorithm at one bit per clock, with a start/busy/done handshake.
- Also produces leading-zero blanking flags per digit.

---
 rtl/bin_to_bcd_seq.sv | 118 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
//==============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Sequential double-dabble binary-to-BCD converter, one bit per clock,
//            with start/busy/done handshake and leading-zero blank flags.
// Revision : 1.0
//==============================================================================
`default_nettype none

module bin_to_bcd_seq #(
  parameter int BIN_W = 10,
  parameter int NDIG  = 4
) (
  input  logic                Clk_In,
  input  logic                Rst_N_In,
  input  logic                Start_In,
  input  logic [BIN_W-1:0]    Bin_In,
  output logic                Busy_Out,
  output logic                Done_Out,
  output logic [4*NDIG-1:0]   Bcd_Out,
  output logic [NDIG-1:0]     Blank_Out
);

  localparam int              W      = 4*NDIG + BIN_W;
  localparam int              CW     = $clog2(BIN_W + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(BIN_W - 1);
  localparam logic [NDIG-1:0] C_BLANK_RST = {{(NDIG-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [W-1:0]        work_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [4*NDIG-1:0]   bcd_q;
  logic [NDIG-1:0]     blank_q;

  logic [W-1:0]        work_adj;
  logic [W-1:0]        work_d;
  logic [NDIG-1:0]     blank_d;

  // Work register is {BCD digits, binary}; only the BCD digits get the add-3.
  assign work_adj[BIN_W-1:0] = work_q[BIN_W-1:0];

  for (genvar i = 0; i < NDIG; i++) begin : g_adj
    assign work_adj[BIN_W+4*i +: 4] = (work_q[BIN_W+4*i +: 4] >= 4'd5) ?
                                      work_q[BIN_W+4*i +: 4] + 4'd3 :
                                      work_q[BIN_W+4*i +: 4];
  end

  assign work_d = work_adj << 1;

  // Blank flags scan down from the MSD using the post-shift digits, so they
  // are valid on the completion edge; the ones digit is never blanked.
  always_comb begin
    logic lead;
    lead    = 1'b1;
    blank_d = '0;
    for (int i = NDIG-1; i > 0; i--) begin
      lead       = lead & (work_d[BIN_W+4*i +: 4] == 4'd0);
      blank_d[i] = lead;
    end
  end

  always_ff @(posedge Clk_In or negedge Rst_N_In) begin
    if (!Rst_N_In) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= C_BLANK_RST;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (Start_In) begin
            work_q  <= {{(4*NDIG){1'b0}}, Bin_In};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CONV: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            bcd_q   <= work_d[W-1:BIN_W];
            blank_q <= blank_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy_Out  = busy_q;
  assign Done_Out  = done_q;
  assign Bcd_Out   = bcd_q;
  assign Blank_Out = blank_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
//==============================================================================
// Module   : tb_bin_to_bcd_seq
// Purpose  : Self-checking bench for bin_to_bcd_seq (vector table + scoreboard).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  bin = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  blank;

  bin_to_bcd_seq #(.BIN_W(10), .NDIG(4)) dut (
    .Clk_In   (clk),
    .Rst_N_In (rst_n),
    .Start_In (start),
    .Bin_In   (bin),
    .Busy_Out (busy),
    .Done_Out (done),
    .Bcd_Out  (bcd),
    .Blank_Out(blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  bin;
    logic [15:0] bcd;
    logic [3:0]  blank;
  } vec_t;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    int          start_cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_pulses = 0;
  int          pushes = 0;
  exp_t        sb[$];
  logic [15:0] last_bcd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every Done pulse must match the oldest pending result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) chk("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
    if (done) begin
      done_pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 bcd=%h (t=%0t)", bcd, $time);
      end else begin
        e = sb.pop_front();
        chk("bcd", {16'b0, bcd}, {16'b0, e.bcd});
        chk("blank", {28'b0, blank}, {28'b0, e.blank});
        chk("latency", cyc - e.start_cyc, 32'd10);
        last_bcd = e.bcd;
      end
    end
  end

  task automatic start_conv(input logic [9:0] v, input logic [15:0] eb, input logic [3:0] bl);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    sb.push_back('{eb, bl, cyc + 1});
    pushes++;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout actual=0 required=1");
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{10'd0,    16'h0000, 4'b1110};
    vecs[1] = '{10'd1023, 16'h1023, 4'b0000};
    vecs[2] = '{10'd999,  16'h0999, 4'b1000};
    vecs[3] = '{10'd7,    16'h0007, 4'b1110};
    vecs[4] = '{10'd100,  16'h0100, 4'b1000};
    vecs[5] = '{10'd10,   16'h0010, 4'b1100};
    vecs[6] = '{10'd1000, 16'h1000, 4'b0000};
    vecs[7] = '{10'd59,   16'h0059, 4'b1100};
    vecs[8] = '{10'd5,    16'h0005, 4'b1110};
    vecs[9] = '{10'd650,  16'h0650, 4'b1000};

    // Reset held, then idle with no Start
    repeat (3) @(negedge clk);
    chk("rst_bcd", {16'b0, bcd}, 32'h0);
    chk("rst_blank", {28'b0, blank}, 32'he);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_bcd", {16'b0, bcd}, 32'h0);
      chk("idle_blank", {28'b0, blank}, 32'he);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
    end

    // Table-driven conversions
    for (int i = 0; i < 10; i++) begin
      start_conv(vecs[i].bin, vecs[i].bcd, vecs[i].blank);
      drain();
      repeat (2) @(negedge clk);
    end

    // Start during CONV is ignored
    start_conv(10'd345, 16'h0345, 4'b1000);
    repeat (2) @(negedge clk);
    @(negedge clk);
    bin   = 10'd600;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (15) @(negedge clk);
    chk("hold_bcd_345", {16'b0, bcd}, 32'h0345);

    // Start held high: back-to-back from DONE, 11-cycle period
    @(negedge clk);
    bin   = 10'd512;
    start = 1'b1;
    sb.push_back('{16'h0512, 4'b1000, cyc + 1});
    sb.push_back('{16'h0088, 4'b1100, cyc + 12});
    pushes += 2;
    wait_done();
    bin = 10'd88;
    wait_done();
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-conversion aborts with no Done
    @(negedge clk);
    bin   = 10'd777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_during_conv", {16'b0, bcd}, {16'b0, last_bcd});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bcd", {16'b0, bcd}, 32'h0);
    chk("arst_blank", {28'b0, blank}, 32'he);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("post_rst_bcd", {16'b0, bcd}, 32'h0);
    start_conv(10'd777, 16'h0777, 4'b1000);
    drain();
    repeat (3) @(negedge clk);

    chk("done_count", done_pulses, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
